// File: rtl/mips_reg_file.sv
// mips_reg_file: MIPS register file with write-first bypass and overflow write suppression/trap
module mips_reg_file #(
  parameter int WSIZE = 32,
  parameter int AW    = 5,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WSIZE-1:0] rs_data,
  output logic [WSIZE-1:0] rt_data,
  input  logic             we,
  input  logic [AW-1:0]    wd_addr,
  input  logic [WSIZE-1:0] wd_data,
  input  logic             wd_ovf,
  input  logic             ovf_clr,
  output logic             ovf_trap,
  output logic [AW-1:0]    ovf_addr,
  output logic [CW-1:0]    ovf_count
);
  logic [WSIZE-1:0] regs [2**AW];
  logic commit, sup;
  assign commit = we & ~wd_ovf & (wd_addr != '0);
  assign sup    = we & wd_ovf;
  // register 0 is never written, so it reads zero from reset onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wd_addr] <= wd_data;
    end
  end
  // write-first bypass; commit already excludes address 0
  always_comb begin
    rs_data = (commit && rs_addr == wd_addr) ? wd_data : regs[rs_addr];
    rt_data = (commit && rt_addr == wd_addr) ? wd_data : regs[rt_addr];
  end
  // trap pulse and destination capture for the exception logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_trap <= 1'b0;
      ovf_addr <= '0;
    end else begin
      ovf_trap <= sup;
      if (sup) ovf_addr <= wd_addr;
    end
  end
  // saturating overflow counter; a clear coinciding with a suppression counts that one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count <= '0;
    else if (ovf_clr) ovf_count <= {{(CW-1){1'b0}}, sup};
    else if (sup && ovf_count != '1) ovf_count <= ovf_count + CW'(1);
  end
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: directed scoreboard bench for mips_reg_file
module tb_mips_reg_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wd_addr = '0;
  logic [31:0] rs_data, rt_data, wd_data = '0;
  logic        we = 1'b0, wd_ovf = 1'b0, ovf_clr = 1'b0;
  logic        ovf_trap;
  logic [4:0]  ovf_addr;
  logic [7:0]  ovf_count;
  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];

  mips_reg_file dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .we(we), .wd_addr(wd_addr),
    .wd_data(wd_data), .wd_ovf(wd_ovf), .ovf_clr(ovf_clr),
    .ovf_trap(ovf_trap), .ovf_addr(ovf_addr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return rs_data;
      1: return rt_data;
      2: return {31'b0, ovf_trap};
      3: return {27'b0, ovf_addr};
      default: return {24'b0, ovf_count};
    endcase
  endfunction

  task automatic chk(string tag, int sel, logic [31:0] e);
    q.push_back('{tag, sel, e});
  endtask

  task automatic drain();
    #1;
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      assert (obs(x.sel) === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs(x.sel), x.exp);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rs_addr = 5;
    chk("rst_trap", 2, 0); chk("rst_addr", 3, 0); chk("rst_count", 4, 0); chk("rst_rs", 0, 0);
    drain();
    cyc(); rst_n = 1'b1;
    we = 1; wd_addr = 5; wd_data = 32'h1234;
    chk("bypass_r5", 0, 32'h1234); drain();
    cyc(); we = 0;
    chk("hold_r5", 0, 32'h1234); drain();
    rst_n = 1'b0;
    chk("async_rst_r5", 0, 0); chk("async_rst_count", 4, 0); drain();
    cyc(); rst_n = 1'b1;
    we = 1; wd_addr = 0; wd_data = 32'hFFFFFFFF; rs_addr = 0; rt_addr = 0;
    chk("zero_nobyp_rs", 0, 0); chk("zero_nobyp_rt", 1, 0); drain();
    cyc(); we = 0;
    chk("zero_after_rs", 0, 0); drain();
    we = 1; wd_addr = 7; wd_data = 32'hDEADBEEF; rs_addr = 7; rt_addr = 7;
    chk("bypass_rs7", 0, 32'hDEADBEEF); chk("bypass_rt7", 1, 32'hDEADBEEF); drain();
    cyc(); we = 0;
    chk("held_rs7", 0, 32'hDEADBEEF); chk("held_rt7", 1, 32'hDEADBEEF); drain();
    we = 1; wd_addr = 3; wd_data = 32'h11;
    cyc();
    wd_data = 32'h80000000; wd_ovf = 1; rs_addr = 3;
    chk("ovf_nobyp_r3", 0, 32'h11); chk("ovf_pre_trap", 2, 0); drain();
    cyc(); we = 0; wd_ovf = 0; cnt_model = 1;
    chk("ovf_trap", 2, 1); chk("ovf_addr3", 3, 3); chk("ovf_count1", 4, 1); chk("ovf_r3_kept", 0, 32'h11); drain();
    cyc();
    chk("ovf_trap_end", 2, 0); drain();
    we = 1; wd_addr = 0; wd_ovf = 1;
    cyc(); we = 0; wd_ovf = 0; cnt_model = 2;
    chk("zero_ovf_trap", 2, 1); chk("zero_ovf_addr", 3, 0); chk("zero_ovf_count", 4, 2); drain();
    cyc();
    we = 0; wd_ovf = 1; wd_addr = 9; wd_data = 32'hAAAA5555; rt_addr = 9;
    chk("we0_nobyp_rt9", 1, 0); drain();
    cyc();
    chk("we0_trap", 2, 0); chk("we0_addr", 3, 0); chk("we0_count", 4, 2); chk("we0_r9", 1, 0); drain();
    we = 1; wd_ovf = 1; wd_addr = 12;
    for (int i = 0; i < 260; i++) begin
      cyc();
      cnt_model = (cnt_model == 255) ? 255 : cnt_model + 1;
      chk("sat_trap", 2, 1); chk("sat_count", 4, 32'(cnt_model)); drain();
    end
    chk("sat_final", 4, 255); chk("sat_addr", 3, 12); drain();
    ovf_clr = 1;
    cyc();
    chk("clr_sup_count", 4, 1); chk("clr_sup_trap", 2, 1); drain();
    we = 0; wd_ovf = 0;
    cyc(); ovf_clr = 0;
    chk("clr_count", 4, 0); chk("clr_trap", 2, 0); drain();
    rs_addr = 7;
    chk("final_r7", 0, 32'hDEADBEEF); drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
General-purpose register file directly upstream of the MIPS ALU: two combinational read ports drive ALU operands A (rs) and B (rt); one write port takes the ALU result R back at the clock edge.
Consumes the ALU overflow flag O so that an overflowing add/sub never commits, as MIPS requires.
Instead, the suppressed write raises a registered overflow trap, captures the destination register and bumps a saturating overflow counter for the exception logic.

Parameters:
WSIZE, 32, data width of every register and data port
AW, 5, register address width; register count is 2**AW
CW, 8, width of the saturating overflow counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rs_addr  input  AW  read port A address
rt_addr  input  AW  read port B address
rs_data  output  WSIZE  read port A data, feeds ALU A
rt_data  output  WSIZE  read port B data, feeds ALU B
we  input  1  write request for this cycle
wd_addr  input  AW  write destination register
wd_data  input  WSIZE  write data, from ALU R
wd_ovf  input  1  ALU overflow flag O for the instruction being written back
ovf_clr  input  1  synchronous clear of ovf_count
ovf_trap  output  1  registered one-cycle pulse: a write was suppressed by overflow
ovf_addr  output  AW  destination of the most recent suppressed write
ovf_count  output  CW  saturating count of suppressed writes

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): all 2**AW registers = 0, ovf_trap = 0, ovf_addr = 0, ovf_count = 0. Read outputs therefore read 0.
- Release of reset is synchronous to clk. The first write can commit on the first rising edge after rst_n goes high.
- Register 0 is hardwired to zero: reading address 0 returns 0 regardless of any write. Writes to address 0 are discarded.
- Commit condition: commit = we & ~wd_ovf & (wd_addr != 0). On a rising edge with commit=1, reg[wd_addr] <= wd_data. Otherwise all registers hold.
- Reads are combinational, zero latency, with write-first bypass:
  - if commit=1 and rs_addr == wd_addr, rs_data = wd_data in the same cycle;
  - otherwise rs_data = reg[rs_addr].
  - rt_data follows the same rule with rt_addr. Both ports may bypass at once.
- Overflow suppression: sup = we & wd_ovf. Address 0 still counts, because an overflowing add to $zero must still trap.
- ovf_trap is registered: ovf_trap <= sup on every edge, so it is high for exactly the cycle after each suppressed write. Back-to-back suppressions keep it high continuously.
- On sup=1, ovf_addr <= wd_addr. Otherwise ovf_addr holds.
- ovf_count update priority per edge:
  - if ovf_clr and sup, ovf_count <= 1;
  - else if ovf_clr, ovf_count <= 0;
  - else if sup and ovf_count != 2**CW-1, ovf_count <= ovf_count+1;
  - else hold. The counter saturates at all-ones and never wraps.
- we=0: wd_ovf, wd_addr and wd_data are ignored entirely. No trap, no write, no bypass.
- Reset mid-operation: an asserted rst_n overrides any pending write or suppression in that cycle. Nothing commits and the counter clears.
- No X propagation: every output is driven from reset onward for all input combinations.

Test Plan:
- Reset and zero register: assert rst_n=0 mid-run after writing reg[5]=0x1234 -> rs_data=0 for rs_addr=5 immediately. Write 0xFFFFFFFF to addr 0 -> rs_addr=0 reads 0.
- Write/read and bypass: we=1, wd_addr=7, wd_data=0xDEADBEEF, rs_addr=rt_addr=7 -> both ports show 0xDEADBEEF in the same cycle. After the edge with we=0, both still read 0xDEADBEEF.
- Overflow suppression: reg[3]=0x11, then we=1, wd_addr=3, wd_data=0x80000000, wd_ovf=1 -> reg[3] stays 0x11 and no bypass (rs_addr=3 reads 0x11). Next cycle ovf_trap=1, ovf_addr=3, ovf_count=1. The following cycle ovf_trap=0.
- Overflow on $zero: we=1, wd_addr=0, wd_ovf=1 -> trap pulse next cycle, ovf_addr=0, count increments.
- Counter saturation and clear: 260 consecutive suppressed writes (CW=8) -> ovf_trap high continuously, ovf_count=255. Then ovf_clr=1 with sup=1 -> ovf_count=1. Then ovf_clr=1 alone -> ovf_count=0.
- we=0 with wd_ovf=1, wd_addr=9 -> no trap, ovf_addr unchanged, reg[9] unchanged, count unchanged.
